// File: rtl/const_table_arbiter.sv
// Constant/immediate table controller: fills the table with DEFAULT_VAL after reset, then
// arbitrates round-robin between decode reads (byte addresses) and config writes (indices).
module const_table_arbiter #(
  parameter int unsigned DEPTH       = 37,
  parameter int unsigned AW          = 6,
  parameter int unsigned DW          = 32,
  parameter int unsigned BASE_ADDR   = 40,
  parameter int unsigned DEFAULT_VAL = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [31:0]   rd_addr,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_index,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          init_done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          prio_wr_q, prio_wr_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;
  logic          init_done_q, init_done_d;

  logic [31:0]   rd_off;
  logic [31:0]   rd_idx;
  logic          rd_addr_bad;
  logic          wr_index_bad;
  logic          rd_grant;
  logic          wr_grant;
  logic [DW-1:0] resp_data;

  // Address decode is done on the full 32-bit offset so wrap-around below BASE_ADDR
  // and far-out-of-range addresses are both rejected.
  assign rd_off       = rd_addr - 32'(BASE_ADDR);
  assign rd_idx       = rd_off >> 2;
  assign rd_addr_bad  = (rd_addr < 32'(BASE_ADDR)) || (rd_addr[1:0] != 2'b00) ||
                        (rd_idx >= 32'(DEPTH));
  assign wr_index_bad = 32'(wr_index) >= 32'(DEPTH);

  assign rd_grant = (state_q == ST_IDLE) && rd_req && (!wr_req || !prio_wr_q);
  assign wr_grant = (state_q == ST_IDLE) && wr_req && (!rd_req || prio_wr_q);

  assign resp_data = resp_err_q ? '0 : mem_rdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      prio_wr_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_wr_q   <= prio_wr_d;
      resp_err_q  <= resp_err_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_wr_d   = prio_wr_q;
    resp_err_d  = resp_err_q;
    rd_data_d   = rd_data_q;
    rd_err_d    = rd_err_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (rd_grant) begin
          state_d    = ST_RESP;
          resp_err_d = rd_addr_bad;
          prio_wr_d  = 1'b1;
        end else if (wr_grant) begin
          prio_wr_d  = 1'b0;
        end
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        // Capture the response so rd_data/rd_err hold once rd_valid drops.
        rd_data_d = resp_data;
        rd_err_d  = resp_err_q;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    rd_ready  = rd_grant;
    wr_ready  = wr_grant;
    rd_valid  = 1'b0;
    rd_data   = rd_data_q;
    rd_err    = rd_err_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    init_done = init_done_q;
    // Memory strobes are suppressed while reset is held so an aborted init cannot write.
    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = DW'(DEFAULT_VAL);
        end
        ST_IDLE: begin
          if (wr_grant && !wr_index_bad) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_index;
            mem_wdata = wr_data;
          end else if (rd_grant && !rd_addr_bad) begin
            mem_en    = 1'b1;
            mem_addr  = rd_idx[AW-1:0];
          end
        end
        ST_RESP: begin
          rd_valid = 1'b1;
          rd_data  = resp_data;
          rd_err   = resp_err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_const_table_arbiter.sv
// Self-checking bench for const_table_arbiter: a behavioural RAM plus a transaction-level
// table model; directed and randomized reads/writes, contention, errors and mid-op reset.
module tb_const_table_arbiter;
  localparam int DEPTH = 37;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int BASE  = 40;
  localparam int DEF   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_addr = '0;
  logic          rd_ready, rd_valid, rd_err;
  logic [DW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_index = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          init_done;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned tbl [DEPTH];
  logic [DW-1:0] ram [64];

  always #5 clk = ~clk;

  const_table_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .BASE_ADDR(BASE), .DEFAULT_VAL(DEF)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err),
    .wr_req(wr_req), .wr_index(wr_index), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference read: decode a byte address against the table model.
  task automatic ref_read(input logic [31:0] a, output bit err, output logic [31:0] data,
                          output int idx);
    longint la;
    la = longint'(a);
    if (la < BASE || (la % 4) != 0 || (la - BASE) / 4 >= DEPTH) begin
      err = 1'b1; data = '0; idx = -1;
    end else begin
      err = 1'b0; idx = int'((la - BASE) / 4); data = tbl[idx];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
      3:       return 32'($urandom_range(0, BASE - 1));
      4:       return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      default: return 32'(BASE + 4 * $urandom_range(DEPTH, DEPTH + 200));
    endcase
  endfunction

  // Called at the negedge where reset has just been released.
  task automatic init_check(input string tag);
    for (int i = 0; i < DEPTH; i++) tbl[i] = DEF;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'(BASE); wr_index = '0; wr_data = 32'hdead;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check({tag, "_init_cycle"},
            {39'd0, rd_ready, wr_ready, init_done, mem_en, mem_we, mem_addr, mem_wdata},
            {39'd0, 3'b000, 2'b11, 6'(i), 32'(DEF)});
      @(negedge clk);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    check({tag, "_init_done"}, {60'd0, init_done, rd_ready, wr_ready, mem_en}, {60'd0, 4'b1000});
    $display("init %s: %0d entries filled", tag, DEPTH);
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    int w;
    w = 0;
    @(negedge clk);
    wr_req = 1'b1; wr_index = idx; wr_data = data;
    #1;
    while (!wr_ready && w < 20) begin @(negedge clk); #1; w++; end
    check("wr_grant", {63'd0, wr_ready}, 64'd1);
    if (int'(idx) < DEPTH) begin
      check("wr_mem", {23'd0, mem_en, mem_we, mem_addr, mem_wdata}, {23'd0, 2'b11, idx, data});
      tbl[idx] = data;
    end else begin
      check("wr_mem_drop", {62'd0, mem_en, mem_we}, 64'd0);
    end
    $display("write idx=%0d data=%0h", idx, data);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit err; logic [31:0] d; int idx; int w;
    w = 0;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && w < 20) begin @(negedge clk); #1; w++; end
    check("rd_grant", {63'd0, rd_ready}, 64'd1);
    ref_read(a, err, d, idx);
    if (!err) check("rd_mem", {56'd0, mem_en, mem_we, mem_addr}, {56'd0, 2'b10, 6'(idx)});
    else      check("rd_mem_err", {62'd0, mem_en, mem_we}, 64'd0);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("rd_resp", {30'd0, rd_valid, rd_err, rd_data}, {30'd0, 1'b1, err, d});
    @(negedge clk);
    #1;
    check("rd_hold", {30'd0, rd_valid, rd_err, rd_data}, {30'd0, 1'b0, err, d});
    $display("read addr=%0d data=%0h err=%0b", a, rd_data, rd_err);
  endtask

  initial begin
    bit exp_rd_side, pend, perr, rd_g, wr_g;
    logic [31:0] pdata;
    int pidx;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_rd", {28'd0, rd_ready, wr_ready, rd_valid, rd_err, rd_data},
          {28'd0, 36'd0});
    check("reset_mem", {23'd0, mem_en, mem_we, mem_addr, mem_wdata, init_done}, 64'd0);

    // T1 init
    @(negedge clk);
    reset = 1'b0;
    init_check("T1");

    // T2 / T3
    do_read(32'd44);
    do_write(6'd0, 32'd25);
    do_read(32'd40);

    // T5 error cases
    do_read(32'd36);
    do_read(32'd42);
    do_read(32'd188);
    do_read(32'd184);
    do_write(6'd40, 32'h1234);
    do_write(6'd36, 32'h77);
    do_read(32'd184);

    // Randomized mix
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) do_write(6'($urandom_range(0, 45)), $urandom);
      else                           do_read(rand_addr());
    end

    // T6 reset during a RESP cycle
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'(BASE + 8);
    #1;
    check("T6_grant", {63'd0, rd_ready}, 64'd1);
    @(negedge clk);
    rd_req = 1'b0;
    reset  = 1'b1;
    #1;
    check("T6_rst_rd", {28'd0, rd_ready, wr_ready, rd_valid, rd_err, rd_data}, 64'd0);
    check("T6_rst_mem", {23'd0, mem_en, mem_we, mem_addr, mem_wdata, init_done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    init_check("T6");

    // T4 contention: both requests held; read wins first after reset
    @(negedge clk);
    exp_rd_side = 1'b1; pend = 1'b0; rd_g = 1'b0; wr_g = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = rand_addr(); wr_index = 6'($urandom_range(0, DEPTH + 4)); wr_data = $urandom;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (pend) begin
        check("T4_resp", {30'd0, rd_valid, rd_err, rd_data}, {30'd0, 1'b1, perr, pdata});
        check("T4_resp_nogrant", {62'd0, rd_ready, wr_ready}, 64'd0);
        $display("contention cycle %0d: resp data=%0h err=%0b", c, rd_data, rd_err);
        pend = 1'b0; rd_g = 1'b0; wr_g = 1'b0;
      end else begin
        check("T4_grant", {61'd0, rd_valid, rd_ready, wr_ready},
              {61'd0, 1'b0, exp_rd_side, !exp_rd_side});
        $display("contention cycle %0d: rd_ready=%0b wr_ready=%0b", c, rd_ready, wr_ready);
        rd_g = exp_rd_side; wr_g = !exp_rd_side;
        if (exp_rd_side) begin
          ref_read(rd_addr, perr, pdata, pidx);
          pend = 1'b1;
        end else if (int'(wr_index) < DEPTH) begin
          tbl[wr_index] = wr_data;
        end
        exp_rd_side = !exp_rd_side;
      end
      @(negedge clk);
      if (rd_g) rd_addr = rand_addr();
      if (wr_g) begin wr_index = 6'($urandom_range(0, DEPTH + 4)); wr_data = $urandom; end
    end
    rd_req = 1'b0; wr_req = 1'b0;

    // Table readback after re-init and contention writes
    for (int i = 0; i < DEPTH; i++) do_read(32'(BASE + 4 * i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
